// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and data access.
// The data side wins ties; a starvation counter forces a fetch grant after MAXWAIT data wins.
module mem_port_arbiter #(
  parameter int MAXWAIT = 4,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_rd,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ready,
  output logic          stall,
  output logic          prot_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] GNT_IF = 3'd1;
  localparam logic [2:0] GNT_DM = 3'd2;
  localparam logic [2:0] ACK_IF = 3'd3;
  localparam logic [2:0] ACK_DM = 3'd4;

  localparam logic [3:0] MAXW = 4'(MAXWAIT);

  logic [2:0]    state_q, state_d;
  logic [3:0]    starv_q, starv_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          prot_err_q, prot_err_d;
  logic          dm_pend;

  assign dm_pend = dm_rd | dm_wr;

  // Arbitration only happens in IDLE, so a request held through its ack is never granted twice.
  always_comb begin
    state_d    = state_q;
    starv_d    = starv_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    prot_err_d = prot_err_q;
    case (state_q)
      IDLE: begin
        if (dm_rd && dm_wr) begin
          prot_err_d = 1'b1;
        end
        if (dm_pend && (starv_q < MAXW)) begin
          state_d = GNT_DM;
          addr_d  = dm_addr;
          wdata_d = dm_wdata;
          we_d    = dm_wr;
          starv_d = if_req ? (starv_q + 4'd1) : 4'd0;
        end else if (if_req) begin
          state_d = GNT_IF;
          addr_d  = if_addr;
          we_d    = 1'b0;
          starv_d = 4'd0;
        end else begin
          starv_d = 4'd0;
        end
      end
      GNT_IF: begin
        if (m_ready) begin
          if_rdata_d = m_rdata;
          state_d    = ACK_IF;
        end
      end
      GNT_DM: begin
        if (m_ready) begin
          if (!we_q) begin
            dm_rdata_d = m_rdata;
          end
          state_d = ACK_DM;
        end
      end
      ACK_IF:  state_d = IDLE;
      ACK_DM:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A reset mid-transaction simply abandons the memory access; m_req falls with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      starv_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      prot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      starv_q    <= starv_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      prot_err_q <= prot_err_d;
    end
  end

  assign m_req    = (state_q == GNT_IF) || (state_q == GNT_DM);
  assign m_we     = we_q;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign if_ack   = (state_q == ACK_IF);
  assign dm_ack   = (state_q == ACK_DM);
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;
  assign prot_err = prot_err_q;

  // Stall drops in the ack cycle so the pipeline can advance past the completed access.
  assign stall = (if_req & ~if_ack) | (dm_pend & ~dm_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed protocol cases plus randomized transactions
// checked against a word-level memory reference and a grant-counting starvation model.
module tb_mem_port_arbiter;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic [31:0] ifRdata;
  logic        ifAck;
  logic        dmRd;
  logic        dmWr;
  logic [31:0] dmAddr;
  logic [31:0] dmWdata;
  logic [31:0] dmRdata;
  logic        dmAck;
  logic        mReq;
  logic        mWe;
  logic [31:0] mAddr;
  logic [31:0] mWdata;
  logic [31:0] mRdata;
  logic        mReady;
  logic        stall;
  logic        protErr;

  int total = 0;
  int bad   = 0;

  logic [31:0] memArr [0:255];
  logic [31:0] refMem [0:255];
  int          memCnt;
  int          memWait;
  logic        spuriousReady;
  logic        memClear;
  logic        preloadReq;
  logic [7:0]  preloadIdx;
  logic [31:0] preloadVal;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAXWAIT(MAXW), .AW(32), .DW(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (ifReq),
    .if_addr  (ifAddr),
    .if_rdata (ifRdata),
    .if_ack   (ifAck),
    .dm_rd    (dmRd),
    .dm_wr    (dmWr),
    .dm_addr  (dmAddr),
    .dm_wdata (dmWdata),
    .dm_rdata (dmRdata),
    .dm_ack   (dmAck),
    .m_req    (mReq),
    .m_we     (mWe),
    .m_addr   (mAddr),
    .m_wdata  (mWdata),
    .m_rdata  (mRdata),
    .m_ready  (mReady),
    .stall    (stall),
    .prot_err (protErr)
  );

  // Memory model: answers memWait cycles after m_req rises, tolerates dropped requests.
  assign mReady = (mReq && (memCnt == memWait)) || spuriousReady;
  assign mRdata = memArr[mAddr[9:2]];

  always @(posedge clk) begin
    if (!mReq || mReady) memCnt <= 0;
    else                 memCnt <= memCnt + 1;
    if (memClear) begin
      for (int i = 0; i < 256; i++) memArr[i] <= '0;
    end else if (preloadReq) begin
      memArr[preloadIdx] <= preloadVal;
    end else if (mReq && mReady && mWe) begin
      memArr[mAddr[9:2]] <= mWdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_m_req"},    mReq,    32'd0);
    checkOutput({tag, "_m_we"},     mWe,     32'd0);
    checkOutput({tag, "_if_ack"},   ifAck,   32'd0);
    checkOutput({tag, "_dm_ack"},   dmAck,   32'd0);
    checkOutput({tag, "_prot_err"}, protErr, 32'd0);
    checkOutput({tag, "_m_addr"},   mAddr,   32'd0);
    checkOutput({tag, "_m_wdata"},  mWdata,  32'd0);
    checkOutput({tag, "_if_rdata"}, ifRdata, 32'd0);
    checkOutput({tag, "_dm_rdata"}, dmRdata, 32'd0);
    checkOutput({tag, "_stall"},    stall,   32'd0);
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    preloadIdx = addr[9:2];
    preloadVal = val;
    preloadReq = 1'b1;
    tick();
    preloadReq = 1'b0;
    refMem[addr[9:2]] = val;
  endtask

  // One transaction from a single requester, starting in IDLE and ending back in IDLE.
  task automatic applyStimulus(input bit isIf, input bit isWrite, input bit both,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int waitCyc, input string tag);
    logic [31:0] prevDm;
    logic [7:0]  idx;
    prevDm  = dmRdata;
    idx     = addr[9:2];
    memWait = waitCyc;
    if (isIf) begin
      ifReq  = 1'b1;
      ifAddr = addr;
    end else begin
      dmRd    = !isWrite || both;
      dmWr    = isWrite;
      dmAddr  = addr;
      dmWdata = wdata;
    end
    tick();
    ifAddr  = ~addr;
    dmAddr  = ~addr;
    dmWdata = ~wdata;
    for (int c = 0; c <= waitCyc; c++) begin
      checkOutput({tag, "_m_req"}, mReq, 32'd1);
      checkOutput({tag, "_m_addr"}, mAddr, addr);
      checkOutput({tag, "_m_we"}, mWe, {31'd0, isWrite});
      if (isWrite) checkOutput({tag, "_m_wdata"}, mWdata, wdata);
      checkOutput({tag, "_stall_busy"}, stall, 32'd1);
      tick();
    end
    checkOutput({tag, "_m_req_done"}, mReq, 32'd0);
    checkOutput({tag, "_stall_ack"}, stall, 32'd0);
    if (isIf) begin
      checkOutput({tag, "_if_ack"}, ifAck, 32'd1);
      checkOutput({tag, "_dm_ack_quiet"}, dmAck, 32'd0);
      checkOutput({tag, "_if_rdata"}, ifRdata, refMem[idx]);
    end else begin
      checkOutput({tag, "_dm_ack"}, dmAck, 32'd1);
      checkOutput({tag, "_if_ack_quiet"}, ifAck, 32'd0);
      if (isWrite) checkOutput({tag, "_dm_rdata_kept"}, dmRdata, prevDm);
      else         checkOutput({tag, "_dm_rdata"}, dmRdata, refMem[idx]);
    end
    ifReq = 1'b0;
    dmRd  = 1'b0;
    dmWr  = 1'b0;
    if (isWrite) refMem[idx] = wdata;
    tick();
    checkOutput({tag, "_if_ack_once"}, ifAck, 32'd0);
    checkOutput({tag, "_dm_ack_once"}, dmAck, 32'd0);
    checkOutput({tag, "_idle_m_req"}, mReq, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          dmWins;
    int          ifGrants;
    bit          expIf;
    int          kind;
    logic [31:0] addr;

    reset = 1'b1; ifReq = 1'b0; ifAddr = '0; dmRd = 1'b0; dmWr = 1'b0;
    dmAddr = '0; dmWdata = '0; memWait = 0; spuriousReady = 1'b0;
    memClear = 1'b1; preloadReq = 1'b0; preloadIdx = '0; preloadVal = '0;
    for (int i = 0; i < 256; i++) refMem[i] = '0;
    tick();
    memClear = 1'b0;
    tick();
    checkResetState("reset");
    reset = 1'b0;
    tick();

    spuriousReady = 1'b1;
    tick();
    tick();
    checkOutput("spurious_m_req", mReq, 32'd0);
    checkOutput("spurious_if_ack", ifAck, 32'd0);
    checkOutput("spurious_dm_ack", dmAck, 32'd0);
    spuriousReady = 1'b0;
    tick();

    preload(32'h10, 32'h8C010004);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 0, "if_read");
    checkOutput("if_read_value", ifRdata, 32'h8C010004);

    applyStimulus(1'b0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 3, "dm_write");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 1, "dm_readback");
    checkOutput("dm_readback_value", dmRdata, 32'hDEADBEEF);

    memWait = 0;
    ifReq = 1'b1; ifAddr = 32'h10; dmRd = 1'b1; dmAddr = 32'h40;
    tick();
    checkOutput("tie_dm_first", mAddr, 32'h40);
    checkOutput("tie_dm_we", mWe, 32'd0);
    checkOutput("tie_stall_gnt", stall, 32'd1);
    tick();
    checkOutput("tie_dm_ack", dmAck, 32'd1);
    checkOutput("tie_if_wait", ifAck, 32'd0);
    checkOutput("tie_stall_dmack", stall, 32'd1);
    checkOutput("tie_dm_rdata", dmRdata, 32'hDEADBEEF);
    dmRd = 1'b0;
    tick();
    checkOutput("tie_idle_m_req", mReq, 32'd0);
    checkOutput("tie_idle_stall", stall, 32'd1);
    tick();
    checkOutput("tie_if_grant", mReq, 32'd1);
    checkOutput("tie_if_addr", mAddr, 32'h10);
    tick();
    checkOutput("tie_if_ack", ifAck, 32'd1);
    checkOutput("tie_if_stall", stall, 32'd0);
    checkOutput("tie_if_rdata", ifRdata, 32'h8C010004);
    ifReq = 1'b0;
    tick();
    tick();

    memWait  = 0;
    dmWins   = 0;
    ifGrants = 0;
    ifReq = 1'b1; ifAddr = 32'h200; dmRd = 1'b1; dmAddr = 32'h204;
    tick();
    for (int g = 0; g < 2 * (MAXW + 1); g++) begin
      expIf = (dmWins >= MAXW);
      checkOutput("starv_m_req", mReq, 32'd1);
      checkOutput("starv_grant", mAddr, expIf ? 32'h200 : 32'h204);
      tick();
      if (expIf) begin
        checkOutput("starv_if_ack", ifAck, 32'd1);
        ifReq = 1'b0;
        dmWins = 0;
        ifGrants++;
      end else begin
        checkOutput("starv_dm_ack", dmAck, 32'd1);
        dmRd = 1'b0;
        dmWins++;
      end
      tick();
      ifReq = 1'b1;
      dmRd  = 1'b1;
      tick();
    end
    checkOutput("starv_if_grants", ifGrants, 32'd2);
    checkOutput("starv_cleared_dm_wins", mAddr, 32'h204);
    tick();
    ifReq = 1'b0;
    dmRd  = 1'b0;
    tick();
    tick();

    checkOutput("prot_before", protErr, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h80, $urandom, 1, "prot");
    checkOutput("prot_set", protErr, 32'd1);

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      addr = 32'h100 + (32'($urandom_range(0, 15)) << 2);
      applyStimulus(kind == 0, kind == 2, 1'b0, addr, $urandom,
                    int'($urandom_range(0, 3)), "rand");
    end
    checkOutput("prot_sticky", protErr, 32'd1);

    memWait = 100;
    dmRd = 1'b1; dmAddr = 32'h44;
    tick();
    checkOutput("midrst_gnt", mReq, 32'd1);
    tick();
    checkOutput("midrst_waiting", mReq, 32'd1);
    reset = 1'b1;
    dmRd  = 1'b0;
    tick();
    checkResetState("midrst");
    reset   = 1'b0;
    memWait = 0;
    tick();
    checkOutput("midrst_no_ack", dmAck, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
